// File: rtl/wed_receiver.sv
// Captures the WED cache-line beats for the outstanding tag and checks the closing response.
// Optional parity checking of tags and data is enabled by defining WED_PARITY_CHECK_EN.
module wed_receiver #(
   parameter int         NUM_BEATS = 2,
   parameter logic [7:0] DONE_CODE = 8'h00
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [7:0]               exp_tag,
   input  logic                     ha_bwvalid,
   input  logic [7:0]               ha_bwtag,
   input  logic                     ha_bwtagpar,
   input  logic [5:0]               ha_bwad,
   input  logic [511:0]             ha_bwdata,
   input  logic [7:0]               ha_bwpar,
   input  logic                     ha_rvalid,
   input  logic [7:0]               ha_rtag,
   input  logic                     ha_rtagpar,
   input  logic [7:0]               ha_response,
   output logic [512*NUM_BEATS-1:0] wed_data,
   output logic                     wed_valid,
   output logic                     busy,
   output logic                     error,
   output logic [2:0]               err_code,
   output logic [7:0]               resp_code
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERROR} state_t;

   localparam logic [5:0]           LP_NUM_BEATS = 6'(NUM_BEATS);
   localparam logic [NUM_BEATS-1:0] LP_FULL_MASK = '1;

   state_t                   r_state, w_state_nxt;
   logic [7:0]               r_tag;
   logic [NUM_BEATS-1:0]     r_mask, w_mask_nxt;
   logic [2:0]               r_err_code, w_err_nxt;
   logic                     r_wed_valid, w_wed_valid_nxt;
   logic [7:0]               r_resp_code;
   logic [512*NUM_BEATS-1:0] r_wed_data;

   logic w_bw_match, w_rsp_match, w_bad_ad, w_wr_beat;
   logic w_bw_par_err, w_rsp_par_err;

   // A start in the same cycle restarts the capture, so it masks any bus activity.
   assign w_bw_match  = (r_state == S_WAIT) && !start && ha_bwvalid && (ha_bwtag == r_tag);
   assign w_rsp_match = (r_state == S_WAIT) && !start && ha_rvalid && (ha_rtag == r_tag);
   assign w_bad_ad    = w_bw_match && (ha_bwad >= LP_NUM_BEATS);

`ifdef WED_PARITY_CHECK_EN
   logic [7:0] w_slice_bad;
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_slice_bad[i] = (ha_bwpar[i] != ~^ha_bwdata[64*i +: 64]);
      end
   end
   assign w_bw_par_err  = w_bw_match && ((ha_bwtagpar != ~^ha_bwtag) || (|w_slice_bad));
   assign w_rsp_par_err = w_rsp_match && (ha_rtagpar != ~^ha_rtag);
`else
   logic w_unused_par;
   assign w_unused_par  = ^{ha_bwtagpar, ha_bwpar, ha_rtagpar};
   assign w_bw_par_err  = 1'b0;
   assign w_rsp_par_err = 1'b0;
`endif

   assign w_wr_beat = w_bw_match && !w_bw_par_err && !w_bad_ad;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The beat is folded into the mask before the response is judged.
   always_comb begin
      w_state_nxt     = r_state;
      w_mask_nxt      = r_mask;
      w_err_nxt       = r_err_code;
      w_wed_valid_nxt = 1'b0;
      if (start) begin
         w_state_nxt = S_WAIT;
         w_mask_nxt  = '0;
         w_err_nxt   = 3'd0;
      end else if (r_state == S_WAIT) begin
         for (int k = 0; k < NUM_BEATS; k++) begin
            if (w_wr_beat && (ha_bwad == 6'(k))) begin
               w_mask_nxt[k] = 1'b1;
            end
         end
         if (w_bw_par_err || w_rsp_par_err) begin
            w_state_nxt = S_ERROR;
            w_err_nxt   = 3'd2;
         end else if (w_bad_ad) begin
            w_state_nxt = S_ERROR;
            w_err_nxt   = 3'd3;
         end else if (w_rsp_match) begin
            if (ha_response != DONE_CODE) begin
               w_state_nxt = S_ERROR;
               w_err_nxt   = 3'd1;
            end else if (w_mask_nxt == LP_FULL_MASK) begin
               w_state_nxt     = S_DONE;
               w_wed_valid_nxt = 1'b1;
            end else begin
               w_state_nxt = S_ERROR;
               w_err_nxt   = 3'd4;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_tag       <= 8'd0;
         r_mask      <= '0;
         r_err_code  <= 3'd0;
         r_wed_valid <= 1'b0;
         r_resp_code <= 8'd0;
         r_wed_data  <= '0;
      end else begin
         r_mask      <= w_mask_nxt;
         r_err_code  <= w_err_nxt;
         r_wed_valid <= w_wed_valid_nxt;
         if (start) begin
            r_tag <= exp_tag;
         end
         if (w_rsp_match) begin
            r_resp_code <= ha_response;
         end
         for (int k = 0; k < NUM_BEATS; k++) begin
            if (w_wr_beat && (ha_bwad == 6'(k))) begin
               r_wed_data[512*k +: 512] <= ha_bwdata;
            end
         end
      end
   end

   assign wed_data  = r_wed_data;
   assign wed_valid = r_wed_valid;
   assign busy      = (r_state == S_WAIT);
   assign error     = (r_state == S_ERROR);
   assign err_code  = r_err_code;
   assign resp_code = r_resp_code;

endmodule

// File: tb/tb_wed_receiver.sv
// Scoreboard bench for wed_receiver: expected outcomes are queued as stimulus is driven
// and popped when the block reports completion or error.
module tb_wed_receiver;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    exp_tag;
   logic          ha_bwvalid;
   logic [7:0]    ha_bwtag;
   logic          ha_bwtagpar;
   logic [5:0]    ha_bwad;
   logic [511:0]  ha_bwdata;
   logic [7:0]    ha_bwpar;
   logic          ha_rvalid;
   logic [7:0]    ha_rtag;
   logic          ha_rtagpar;
   logic [7:0]    ha_response;
   logic [1023:0] wed_data;
   logic          wed_valid;
   logic          busy;
   logic          error;
   logic [2:0]    err_code;
   logic [7:0]    resp_code;

   typedef struct {
      bit            is_err;
      logic [2:0]    code;
      logic [1023:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clock = ~clock;

   wed_receiver dut (
      .clock(clock), .reset(reset), .start(start), .exp_tag(exp_tag),
      .ha_bwvalid(ha_bwvalid), .ha_bwtag(ha_bwtag), .ha_bwtagpar(ha_bwtagpar),
      .ha_bwad(ha_bwad), .ha_bwdata(ha_bwdata), .ha_bwpar(ha_bwpar),
      .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_rtagpar(ha_rtagpar),
      .ha_response(ha_response),
      .wed_data(wed_data), .wed_valid(wed_valid), .busy(busy), .error(error),
      .err_code(err_code), .resp_code(resp_code)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic idle_bus();
      start      = 1'b0;
      ha_bwvalid = 1'b0;
      ha_rvalid  = 1'b0;
   endtask

   task automatic set_beat(input logic [7:0] tag, input logic [5:0] ad,
                           input logic [511:0] d, input bit flip3);
      ha_bwvalid  = 1'b1;
      ha_bwtag    = tag;
      ha_bwtagpar = ~^tag;
      ha_bwad     = ad;
      ha_bwdata   = d;
      for (int i = 0; i < 8; i++) ha_bwpar[i] = ~^d[64*i +: 64];
      if (flip3) ha_bwpar[3] = ~ha_bwpar[3];
   endtask

   task automatic set_resp(input logic [7:0] tag, input logic [7:0] code);
      ha_rvalid   = 1'b1;
      ha_rtag     = tag;
      ha_rtagpar  = ~^tag;
      ha_response = code;
   endtask

   task automatic arm(input logic [7:0] tag);
      start   = 1'b1;
      exp_tag = tag;
      tick();
      start   = 1'b0;
   endtask

   task automatic push_ok(input logic [511:0] b0, input logic [511:0] b1);
      exp_t e;
      e.is_err = 1'b0;
      e.code   = 3'd0;
      e.data   = {b1, b0};
      sb.push_back(e);
   endtask

   task automatic push_err(input logic [2:0] code);
      exp_t e;
      e.is_err = 1'b1;
      e.code   = code;
      e.data   = '0;
      sb.push_back(e);
   endtask

   // Bounded wait for the block to report an outcome.
   task automatic wait_out(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (wed_valid || error) begin
            timed_out = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_bus();
      tick();
      tick();
      n_total++;
      if (wed_data !== '0 || wed_valid !== 1'b0 || busy !== 1'b0 || error !== 1'b0 ||
          err_code !== 3'd0 || resp_code !== 8'd0)
         $display("FAIL reset_state: valid=%0b busy=%0b error=%0b code=%0d resp=%h data_nz=%0b want all zero",
                  wed_valid, busy, error, err_code, resp_code, |wed_data);
      else n_pass++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [511:0] a, b;
      exp_t e;
      bit to;
      a = rnd512();
      b = rnd512();
      arm(8'hFF);
      n_total++;
      if (busy !== 1'b1) $display("FAIL basic_busy: busy=%0b want 1", busy);
      else n_pass++;
      set_beat(8'hFF, 6'd0, a, 1'b0);
      tick();
      set_beat(8'hFF, 6'd1, b, 1'b0);
      tick();
      idle_bus();
      set_resp(8'hFF, 8'h00);
      push_ok(a, b);
      tick();
      idle_bus();
      n_total++;
      if (wed_valid !== 1'b1 || busy !== 1'b0)
         $display("FAIL basic_latency: wed_valid=%0b busy=%0b want 1 0", wed_valid, busy);
      else n_pass++;
      wait_out(to);
      e = sb.pop_front();
      n_total++;
      if (to || error !== e.is_err || err_code !== e.code || wed_data !== e.data)
         $display("FAIL basic_outcome: timeout=%0b error=%0b code=%0d data_ok=%0b want error=%0b code=%0d",
                  to, error, err_code, wed_data === e.data, e.is_err, e.code);
      else n_pass++;
      tick();
      n_total++;
      if (wed_valid !== 1'b0 || wed_data !== e.data)
         $display("FAIL basic_pulse: wed_valid=%0b data_held=%0b want 0 1", wed_valid, wed_data === e.data);
      else n_pass++;
   endtask

   task automatic test_out_of_order();
      logic [511:0] a, b;
      exp_t e;
      bit to;
      a = rnd512();
      b = rnd512();
      arm(8'h5A);
      set_beat(8'h5A, 6'd1, b, 1'b0);
      tick();
      set_beat(8'h5A, 6'd0, a, 1'b0);
      set_resp(8'h5A, 8'h00);
      push_ok(a, b);
      tick();
      idle_bus();
      n_total++;
      if (wed_valid !== 1'b1) $display("FAIL ooo_latency: wed_valid=%0b want 1", wed_valid);
      else n_pass++;
      wait_out(to);
      e = sb.pop_front();
      n_total++;
      if (to || error !== e.is_err || err_code !== e.code || wed_data !== e.data)
         $display("FAIL ooo_outcome: timeout=%0b error=%0b code=%0d lo=%h want lo=%h",
                  to, error, err_code, wed_data[63:0], e.data[63:0]);
      else n_pass++;
      tick();
   endtask

   task automatic test_missing_beat();
      exp_t e;
      bit to;
      arm(8'hFF);
      set_beat(8'hFF, 6'd0, rnd512(), 1'b0);
      tick();
      idle_bus();
      set_resp(8'hFF, 8'h00);
      push_err(3'd4);
      tick();
      idle_bus();
      n_total++;
      if (wed_valid !== 1'b0) $display("FAIL missing_no_valid: wed_valid=%0b want 0", wed_valid);
      else n_pass++;
      wait_out(to);
      e = sb.pop_front();
      n_total++;
      if (to || error !== e.is_err || err_code !== e.code)
         $display("FAIL missing_outcome: timeout=%0b error=%0b code=%0d want error=%0b code=%0d",
                  to, error, err_code, e.is_err, e.code);
      else n_pass++;
   endtask

   task automatic test_bad_response();
      exp_t e;
      bit to;
      arm(8'hFF);
      n_total++;
      if (error !== 1'b0 || err_code !== 3'd0 || busy !== 1'b1)
         $display("FAIL restart_clears: error=%0b code=%0d busy=%0b want 0 0 1", error, err_code, busy);
      else n_pass++;
      set_beat(8'hFF, 6'd0, rnd512(), 1'b0);
      tick();
      set_beat(8'hFF, 6'd1, rnd512(), 1'b0);
      tick();
      idle_bus();
      set_resp(8'hFF, 8'h01);
      push_err(3'd1);
      tick();
      idle_bus();
      wait_out(to);
      e = sb.pop_front();
      n_total++;
      if (to || error !== e.is_err || err_code !== e.code || resp_code !== 8'h01 || wed_valid !== 1'b0)
         $display("FAIL badresp_outcome: timeout=%0b error=%0b code=%0d resp=%h valid=%0b want code=%0d resp=01",
                  to, error, err_code, resp_code, wed_valid, e.code);
      else n_pass++;
   endtask

   task automatic test_tag_filter();
      logic [511:0] keep;
      exp_t e;
      bit to;
      keep = wed_data[511:0];
      arm(8'hFF);
      set_beat(8'h10, 6'd0, rnd512(), 1'b0);
      tick();
      set_beat(8'hFF, 6'd1, rnd512(), 1'b0);
      tick();
      idle_bus();
      n_total++;
      if (busy !== 1'b1 || error !== 1'b0 || wed_data[511:0] !== keep)
         $display("FAIL tag_ignored: busy=%0b error=%0b beat0_kept=%0b want 1 0 1",
                  busy, error, wed_data[511:0] === keep);
      else n_pass++;
      set_resp(8'hFF, 8'h00);
      push_err(3'd4);
      tick();
      idle_bus();
      wait_out(to);
      e = sb.pop_front();
      n_total++;
      if (to || error !== e.is_err || err_code !== e.code)
         $display("FAIL tag_mask_outcome: timeout=%0b error=%0b code=%0d want code=%0d", to, error, err_code, e.code);
      else n_pass++;
      arm(8'hFF);
      set_beat(8'hFF, 6'd2, rnd512(), 1'b0);
      push_err(3'd3);
      tick();
      idle_bus();
      wait_out(to);
      e = sb.pop_front();
      n_total++;
      if (to || error !== e.is_err || err_code !== e.code)
         $display("FAIL bad_addr_outcome: timeout=%0b error=%0b code=%0d want code=%0d", to, error, err_code, e.code);
      else n_pass++;
   endtask

   task automatic test_parity();
      logic [511:0] a, b, keep;
      exp_t e;
      bit to;
      a = rnd512();
      b = rnd512();
      keep = wed_data[511:0];
      arm(8'hC3);
      set_beat(8'hC3, 6'd0, a, 1'b1);
`ifdef WED_PARITY_CHECK_EN
      push_err(3'd2);
`else
      push_ok(a, b);
`endif
      tick();
      set_beat(8'hC3, 6'd1, b, 1'b0);
      tick();
      idle_bus();
      set_resp(8'hC3, 8'h00);
      tick();
      idle_bus();
      wait_out(to);
      e = sb.pop_front();
      n_total++;
      if (to || error !== e.is_err || err_code !== e.code)
         $display("FAIL parity_outcome: timeout=%0b error=%0b code=%0d want error=%0b code=%0d",
                  to, error, err_code, e.is_err, e.code);
      else n_pass++;
      n_total++;
`ifdef WED_PARITY_CHECK_EN
      if (wed_data[511:0] !== keep)
         $display("FAIL parity_no_write: beat0=%h want %h", wed_data[63:0], keep[63:0]);
      else n_pass++;
`else
      if (wed_data !== e.data)
         $display("FAIL parity_data: lo=%h want %h", wed_data[63:0], e.data[63:0]);
      else n_pass++;
`endif
      tick();
   endtask

   task automatic test_reset_mid();
      arm(8'hFF);
      set_beat(8'hFF, 6'd0, rnd512(), 1'b0);
      tick();
      idle_bus();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_total++;
      if (wed_data !== '0 || wed_valid !== 1'b0 || busy !== 1'b0 || error !== 1'b0 ||
          err_code !== 3'd0 || resp_code !== 8'd0)
         $display("FAIL reset_mid_state: valid=%0b busy=%0b error=%0b code=%0d resp=%h data_nz=%0b want all zero",
                  wed_valid, busy, error, err_code, resp_code, |wed_data);
      else n_pass++;
      set_resp(8'hFF, 8'h00);
      tick();
      idle_bus();
      tick();
      n_total++;
      if (wed_valid !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || resp_code !== 8'd0)
         $display("FAIL late_resp_ignored: valid=%0b busy=%0b error=%0b resp=%h want 0 0 0 00",
                  wed_valid, busy, error, resp_code);
      else n_pass++;
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      exp_tag     = 8'd0;
      ha_bwvalid  = 1'b0;
      ha_bwtag    = 8'd0;
      ha_bwtagpar = 1'b0;
      ha_bwad     = 6'd0;
      ha_bwdata   = '0;
      ha_bwpar    = 8'd0;
      ha_rvalid   = 1'b0;
      ha_rtag     = 8'd0;
      ha_rtagpar  = 1'b0;
      ha_response = 8'd0;
      test_reset();
      test_basic();
      test_out_of_order();
      test_missing_beat();
      test_bad_response();
      test_tag_filter();
      test_parity();
      test_reset_mid();
      n_total++;
      if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
